// File: rtl/ppa_pkg.sv
// Shared parallel-prefix definitions for the Brent-Kung adder/subtractor family.
package ppa_pkg;

    localparam int unsigned WIDTH = 8;

    // Generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: hi spans the more significant bits, lo the less significant ones.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Black/grey prefix cell; grey cells (GEN_P = 0) tie pout low.
module bk_prefix_cell
    import ppa_pkg::*;
#(
    parameter bit GEN_P = 1'b1
) (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic gout,
    output logic pout
);

    gp_t hi;
    gp_t lo;
    gp_t res;

    // One level of the prefix operator.
    always_comb begin
        hi   = '{g: gh, p: ph};
        lo   = '{g: gl, p: pl};
        res  = gp_combine(hi, lo);
        gout = res.g;
        pout = GEN_P ? res.p : 1'b0;
    end

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage pipelined 8-bit Brent-Kung subtractor (a - b - bin) on a valid/ready stream.
module bk_sub_pipe #(
    parameter int unsigned WIDTH = ppa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import ppa_pkg::*;

    // Position 0 is the injected carry-in (g = ~bin, p = 0); position k holds operand bit k-1.
    gp_t [WIDTH:0]    leaf;
    logic [WIDTH-1:0] p_raw;

    // Pre-processing: a + ~b + ~bin.
    always_comb begin
        leaf[0] = '{g: ~bin, p: 1'b0};
        for (int i = 0; i < int'(WIDTH); i++) begin
            leaf[i+1] = '{g: a[i] & ~b[i], p: a[i] ^ ~b[i]};
            p_raw[i]  = a[i] ^ ~b[i];
        end
    end

    // ---------------- Up-sweep (stage 1) ----------------
    logic n1_1_g, n1_3_g, n1_3_p, n1_5_g, n1_5_p, n1_7_g, n1_7_p;
    logic n2_3_g, n2_7_g, n2_7_p, n3_7_g;
    logic unused_p1_1, unused_p2_3, unused_p3_7;

    // Row 1: span 2. Any group reaching position 0 has p = 0, hence grey.
    bk_prefix_cell #(.GEN_P(1'b0)) u_r1_1 (
        .gh(leaf[1].g), .ph(leaf[1].p), .gl(leaf[0].g), .pl(leaf[0].p),
        .gout(n1_1_g), .pout(unused_p1_1)
    );
    bk_prefix_cell #(.GEN_P(1'b1)) u_r1_3 (
        .gh(leaf[3].g), .ph(leaf[3].p), .gl(leaf[2].g), .pl(leaf[2].p),
        .gout(n1_3_g), .pout(n1_3_p)
    );
    bk_prefix_cell #(.GEN_P(1'b1)) u_r1_5 (
        .gh(leaf[5].g), .ph(leaf[5].p), .gl(leaf[4].g), .pl(leaf[4].p),
        .gout(n1_5_g), .pout(n1_5_p)
    );
    bk_prefix_cell #(.GEN_P(1'b1)) u_r1_7 (
        .gh(leaf[7].g), .ph(leaf[7].p), .gl(leaf[6].g), .pl(leaf[6].p),
        .gout(n1_7_g), .pout(n1_7_p)
    );

    // Row 2: span 4.
    bk_prefix_cell #(.GEN_P(1'b0)) u_r2_3 (
        .gh(n1_3_g), .ph(n1_3_p), .gl(n1_1_g), .pl(1'b0),
        .gout(n2_3_g), .pout(unused_p2_3)
    );
    bk_prefix_cell #(.GEN_P(1'b1)) u_r2_7 (
        .gh(n1_7_g), .ph(n1_7_p), .gl(n1_5_g), .pl(n1_5_p),
        .gout(n2_7_g), .pout(n2_7_p)
    );

    // Row 3: span 8.
    bk_prefix_cell #(.GEN_P(1'b0)) u_r3_7 (
        .gh(n2_7_g), .ph(n2_7_p), .gl(n2_3_g), .pl(1'b0),
        .gout(n3_7_g), .pout(unused_p3_7)
    );

    // Group generates after the up-sweep, indexed by tree position.
    logic [WIDTH:0] up_g;
    assign up_g = {leaf[8].g, n3_7_g, leaf[6].g, n1_5_g, leaf[4].g,
                   n2_3_g, leaf[2].g, n1_1_g, leaf[0].g};

    // ---------------- Handshake ----------------
    logic s1_v;
    logic s2_v;
    logic s1_load;
    logic adv2;

    assign adv2      = s1_v & (~s2_v | out_ready);
    assign in_ready  = rst | ~s1_v | adv2;
    assign s1_load   = in_valid & in_ready & ~rst;
    assign out_valid = s2_v;

    // Valid bits: the only reset state in the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_load)
                s1_v <= 1'b1;
            else if (adv2)
                s1_v <= 1'b0;
            if (adv2)
                s2_v <= 1'b1;
            else if (out_ready)
                s2_v <= 1'b0;
        end
    end

    // ---------------- Stage 1 register bank ----------------
    logic [WIDTH:0]   s1_g;
    logic             s1_p5;
    logic [WIDTH-1:0] s1_p;
    logic             s1_a7;
    logic             s1_b7;

    // Capture up-sweep results and the raw propagates on acceptance.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_g  <= up_g;
            s1_p5 <= n1_5_p;
            s1_p  <= p_raw;
            s1_a7 <= a[WIDTH-1];
            s1_b7 <= b[WIDTH-1];
        end
    end

    // ---------------- Down-sweep (stage 2) ----------------
    logic d4_5_g, d4_8_g, d5_2_g, d5_4_g, d5_6_g;
    logic unused_p4_5, unused_p4_8, unused_p5_2, unused_p5_4, unused_p5_6;

    // Row 4: prefix into position 5 and the final carry-out.
    bk_prefix_cell #(.GEN_P(1'b0)) u_r4_5 (
        .gh(s1_g[5]), .ph(s1_p5), .gl(s1_g[3]), .pl(1'b0),
        .gout(d4_5_g), .pout(unused_p4_5)
    );
    bk_prefix_cell #(.GEN_P(1'b0)) u_r4_8 (
        .gh(s1_g[8]), .ph(s1_p[7]), .gl(s1_g[7]), .pl(1'b0),
        .gout(d4_8_g), .pout(unused_p4_8)
    );

    // Row 5: fill in the remaining even positions.
    bk_prefix_cell #(.GEN_P(1'b0)) u_r5_2 (
        .gh(s1_g[2]), .ph(s1_p[1]), .gl(s1_g[1]), .pl(1'b0),
        .gout(d5_2_g), .pout(unused_p5_2)
    );
    bk_prefix_cell #(.GEN_P(1'b0)) u_r5_4 (
        .gh(s1_g[4]), .ph(s1_p[3]), .gl(s1_g[3]), .pl(1'b0),
        .gout(d5_4_g), .pout(unused_p5_4)
    );
    bk_prefix_cell #(.GEN_P(1'b0)) u_r5_6 (
        .gh(s1_g[6]), .ph(s1_p[5]), .gl(d4_5_g), .pl(1'b0),
        .gout(d5_6_g), .pout(unused_p5_6)
    );

    // Carry into bit i is the prefix generate ending at position i.
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;

    // Post-processing: sum bits and signed overflow.
    always_comb begin
        carry  = {s1_g[7], d5_6_g, d4_5_g, d5_4_g, s1_g[3], d5_2_g, s1_g[1], s1_g[0]};
        diff_c = s1_p ^ carry;
        ovf_c  = (s1_a7 ^ s1_b7) & (s1_a7 ^ diff_c[WIDTH-1]);
    end

    // ---------------- Stage 2 register bank ----------------
    // Result registers move only when S2 advances, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (adv2) begin
            diff <= diff_c;
            bout <= ~d4_8_g;
            ovf  <= ovf_c;
        end
    end

endmodule
